// File: rtl/hazard_flush_ctrl_if.sv
// Hazard-controller port bundle: pipeline status into the controller,
// stall/flush/hold controls back out to the pipeline buffers.
//   slave  : the hazard controller (consumes status, drives controls)
//   master : the pipeline datapath (drives status, consumes controls)
// Optional statistics ports STALL_CNT/FLUSH_CNT exist only when the macro
// HAZARD_STATS_EN is defined.
interface hazard_flush_ctrl_if #(
  parameter int unsigned REG_AW = 4
`ifdef HAZARD_STATS_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
);

  // Pipeline status
  logic              IDEX_MemRead;
  logic [REG_AW-1:0] IDEX_RT;
  logic [REG_AW-1:0] IFID_RS;
  logic [REG_AW-1:0] IFID_RT;
  logic              IFID_UsesRT;
  logic              BRANCH_TAKEN;
  logic              EXMEM_MemAccess;
  logic              DMEM_READY;

  // Pipeline controls
  logic              PC_WRITE;
  logic              IFID_WRITE;
  logic              IFID_FLUSH;
  logic              IDEX_FLUSH;
  logic              PIPE_HOLD;
  logic              MEM_ERR;
  logic [1:0]        STATE;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0]  STALL_CNT;
  logic [CNT_W-1:0]  FLUSH_CNT;
`endif

  modport slave (
    input  IDEX_MemRead, IDEX_RT, IFID_RS, IFID_RT, IFID_UsesRT,
           BRANCH_TAKEN, EXMEM_MemAccess, DMEM_READY,
    output PC_WRITE, IFID_WRITE, IFID_FLUSH, IDEX_FLUSH, PIPE_HOLD,
           MEM_ERR, STATE
`ifdef HAZARD_STATS_EN
    ,
    output STALL_CNT, FLUSH_CNT
`endif
  );

  modport master (
    output IDEX_MemRead, IDEX_RT, IFID_RS, IFID_RT, IFID_UsesRT,
           BRANCH_TAKEN, EXMEM_MemAccess, DMEM_READY,
    input  PC_WRITE, IFID_WRITE, IFID_FLUSH, IDEX_FLUSH, PIPE_HOLD,
           MEM_ERR, STATE
`ifdef HAZARD_STATS_EN
    ,
    input  STALL_CNT, FLUSH_CNT
`endif
  );

endinterface

// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard controller. Detects load-use hazards and EX-resolved taken
// branches, drives PC / IF-ID write enables and IF/ID, ID/EX flushes, and
// freezes the pipeline while data memory is not ready (with a timeout that
// raises a sticky MEM_ERR). Outputs are Mealy: combinational from the
// registered state and the current inputs.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : hazard_flush_ctrl_if.slave (status in, controls out,
//                STATE debug: 00 RUN, 01 FLUSH, 10 MEMWAIT)
// Optional feature macro: HAZARD_STATS_EN adds saturating STALL_CNT and
// FLUSH_CNT statistics counters on the interface.
module hazard_flush_ctrl #(
  parameter int unsigned REG_AW          = 4,
  parameter int unsigned BR_FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT     = 64,
  parameter int unsigned CNT_W           = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_flush_ctrl_if.slave bus
);

  localparam int unsigned FC_W   = (BR_FLUSH_CYCLES > 1) ? $clog2(BR_FLUSH_CYCLES) : 1;
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);

  localparam logic [FC_W-1:0]   FLUSH_INIT = FC_W'(BR_FLUSH_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);

  // Reject illegal configurations at elaboration time
  if (BR_FLUSH_CYCLES < 1 || BR_FLUSH_CYCLES > 8 || MEM_TIMEOUT < 2 || CNT_W < 1) begin : g_bad_cfg
    $error("hazard_flush_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_FLUSH   = 2'b01,
    ST_MEMWAIT = 2'b10
  } state_t;

  state_t              state_q, state_d;
  state_t              ret_q, ret_d;
  state_t              act_state;
  logic [FC_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                force_q, force_d;
  logic                mem_err_q, mem_err_d;

  logic [REG_AW-1:0]   ex_rt;
  logic [REG_AW-1:0]   id_rs;
  logic [REG_AW-1:0]   id_rt;
  logic                load_use;
  logic                mem_hold;

  logic                pc_write;
  logic                ifid_write;
  logic                ifid_flush;
  logic                idex_flush;
  logic                pipe_hold;

  assign ex_rt = bus.IDEX_RT;
  assign id_rs = bus.IFID_RS;
  assign id_rt = bus.IFID_RT;

  // Load-use: every register compares, R0 included
  assign load_use = bus.IDEX_MemRead &
                    ((ex_rt == id_rs) | (bus.IFID_UsesRT & (ex_rt == id_rt)));

  // After a timeout the following cycle is treated as ready regardless of DMEM_READY
  assign mem_hold = bus.EXMEM_MemAccess & ~bus.DMEM_READY & ~force_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      ret_q       <= ST_RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      force_q     <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      force_q     <= force_d;
      mem_err_q   <= mem_err_d;
    end
  end

  // Next state and Mealy outputs; priority mem-wait > branch/flush > load-use
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    force_d     = 1'b0;
    mem_err_d   = mem_err_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pipe_hold   = 1'b0;

    // Leaving MEMWAIT behaves exactly like a cycle in the saved state
    act_state = (state_q == ST_MEMWAIT) ? ret_q : state_q;

    if (mem_hold) begin
      pipe_hold  = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      state_d    = ST_MEMWAIT;
      if (state_q == ST_MEMWAIT) begin
        if (wait_cnt_q == WAIT_LAST) begin
          mem_err_d = 1'b1;
          force_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end else begin
        // First held cycle: remember where to resume, flush_cnt stays frozen
        ret_d      = state_q;
        wait_cnt_d = WAIT_W'(1);
      end
    end else begin
      state_d    = act_state;
      wait_cnt_d = '0;
      case (act_state)
        ST_FLUSH: begin
          // EX and ID hold bubbles, so branch and load-use are ignored here
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          flush_cnt_d = flush_cnt_q - FC_W'(1);
          if (flush_cnt_q == FC_W'(1)) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          if (bus.BRANCH_TAKEN) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            if (BR_FLUSH_CYCLES > 1) begin
              state_d     = ST_FLUSH;
              flush_cnt_d = FLUSH_INIT;
            end
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end
        end
      endcase
    end

    // Reset forces the bubble pattern immediately, independent of the clock
    if (!rst_n) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      pipe_hold  = 1'b0;
    end
  end

  assign bus.PC_WRITE   = pc_write;
  assign bus.IFID_WRITE = ifid_write;
  assign bus.IFID_FLUSH = ifid_flush;
  assign bus.IDEX_FLUSH = idex_flush;
  assign bus.PIPE_HOLD  = pipe_hold;
  assign bus.MEM_ERR    = mem_err_q;
  assign bus.STATE      = state_q;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_stat_q;

  // Saturating statistics: stall cycles (PC held) and ID/EX flush cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      flush_stat_q <= '0;
    end else begin
      if (!pc_write && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (idex_flush && (flush_stat_q != '1)) begin
        flush_stat_q <= flush_stat_q + CNT_W'(1);
      end
    end
  end

  assign bus.STALL_CNT = stall_cnt_q;
  assign bus.FLUSH_CNT = flush_stat_q;
`endif

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Self-checking bench for hazard_flush_ctrl: directed scenarios followed by
// constrained-random traffic, all checked against a cycle-level reference
// model built from the hazard rules (remaining flush cycles, consecutive
// hold cycles, sticky error).
module tb_hazard_flush_ctrl;

  localparam int TB_BR      = 3;
  localparam int TB_TIMEOUT = 8;

  logic clk;
  logic rst_n;

  hazard_flush_ctrl_if #(.REG_AW(4)) bus ();

  hazard_flush_ctrl #(
    .REG_AW         (4),
    .BR_FLUSH_CYCLES(TB_BR),
    .MEM_TIMEOUT    (TB_TIMEOUT),
    .CNT_W          (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model
  int m_flush_left;   // flush cycles still owed to a taken branch
  int m_held;         // consecutive not-ready cycles so far
  bit m_grace;        // this cycle is forced ready after a timeout
  bit m_err;
  bit m_prev_hold;    // previous cycle froze the pipeline
  int m_stall;
  int m_flushes;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_flush_left = 0;
    m_held       = 0;
    m_grace      = 0;
    m_err        = 0;
    m_prev_hold  = 0;
    m_stall      = 0;
    m_flushes    = 0;
  endtask

  task automatic quiet_inputs();
    bus.BRANCH_TAKEN    = 1'b0;
    bus.IDEX_MemRead    = 1'b0;
    bus.IDEX_RT         = 4'd0;
    bus.IFID_RS         = 4'd0;
    bus.IFID_RT         = 4'd0;
    bus.IFID_UsesRT     = 1'b0;
    bus.EXMEM_MemAccess = 1'b0;
    bus.DMEM_READY      = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc_write"},   bus.PC_WRITE,   1'b0);
    check({tag, "_ifid_write"}, bus.IFID_WRITE, 1'b0);
    check({tag, "_ifid_flush"}, bus.IFID_FLUSH, 1'b1);
    check({tag, "_idex_flush"}, bus.IDEX_FLUSH, 1'b1);
    check({tag, "_pipe_hold"},  bus.PIPE_HOLD,  1'b0);
    check({tag, "_mem_err"},    bus.MEM_ERR,    1'b0);
    check({tag, "_state"},      bus.STATE,      2'b00);
`ifdef HAZARD_STATS_EN
    check({tag, "_stall_cnt"},  bus.STALL_CNT,  16'd0);
    check({tag, "_flush_cnt"},  bus.FLUSH_CNT,  16'd0);
`endif
  endtask

  // Assert reset in the middle of a cycle and check outputs react at once
  task automatic mid_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    quiet_inputs();
    #1;
    check_reset_outputs(tag);
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs({tag, "_held"});
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive at negedge, compare against the model, then advance it
  task automatic step(input logic br, input logic mr, input logic [3:0] ex_rt,
                      input logic [3:0] rs, input logic [3:0] rt, input logic uses,
                      input logic ma, input logic rdy);
    bit   hold;
    bit   lu;
    logic e_pcw, e_ifw, e_iff, e_idf, e_hold;
    logic [1:0] e_st;
    @(negedge clk);
    bus.BRANCH_TAKEN    = br;
    bus.IDEX_MemRead    = mr;
    bus.IDEX_RT         = ex_rt;
    bus.IFID_RS         = rs;
    bus.IFID_RT         = rt;
    bus.IFID_UsesRT     = uses;
    bus.EXMEM_MemAccess = ma;
    bus.DMEM_READY      = rdy;
    #1;
    cyc++;

    e_st   = m_prev_hold ? 2'b10 : ((m_flush_left > 0) ? 2'b01 : 2'b00);
    hold   = ma && !rdy && !m_grace;
    lu     = mr && ((ex_rt == rs) || (uses && (ex_rt == rt)));
    e_pcw  = 1'b1;
    e_ifw  = 1'b1;
    e_iff  = 1'b0;
    e_idf  = 1'b0;
    e_hold = 1'b0;
    if (hold) begin
      e_hold = 1'b1;
      e_pcw  = 1'b0;
      e_ifw  = 1'b0;
    end else if (m_flush_left > 0 || br) begin
      e_iff = 1'b1;
      e_idf = 1'b1;
    end else if (lu) begin
      e_pcw = 1'b0;
      e_ifw = 1'b0;
      e_idf = 1'b1;
    end

    check("pc_write",   bus.PC_WRITE,   e_pcw);
    check("ifid_write", bus.IFID_WRITE, e_ifw);
    check("ifid_flush", bus.IFID_FLUSH, e_iff);
    check("idex_flush", bus.IDEX_FLUSH, e_idf);
    check("pipe_hold",  bus.PIPE_HOLD,  e_hold);
    check("mem_err",    bus.MEM_ERR,    m_err);
    check("state",      bus.STATE,      e_st);
`ifdef HAZARD_STATS_EN
    check("stall_cnt",  bus.STALL_CNT,  16'(m_stall));
    check("flush_cnt",  bus.FLUSH_CNT,  16'(m_flushes));
`endif

    if (hold) begin
      m_held++;
      if (m_held == TB_TIMEOUT) begin
        m_err   = 1;
        m_grace = 1;
        m_held  = 0;
      end
    end else begin
      m_held  = 0;
      m_grace = 0;
      if (m_flush_left > 0) m_flush_left--;
      else if (br)          m_flush_left = TB_BR - 1;
    end
    m_prev_hold = hold;
    if (!e_pcw && m_stall < 65535)   m_stall++;
    if (e_idf && m_flushes < 65535)  m_flushes++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'd0, 4'd1, 4'd2, 0, 0, 1);
  endtask

  logic       r_br, r_ma;
  logic [3:0] r_ex, r_rs, r_rt;

  initial begin
    rst_n = 1'b0;
    quiet_inputs();
    model_reset();
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    idle(2);

    // Load-use on RS, not on RT when RT is unused, then RT used, then R0
    step(0, 1, 4'd3, 4'd3, 4'd0, 0, 0, 1);
    check("lu_rs_pc_write", bus.PC_WRITE, 1'b0);
    check("lu_rs_idex_flush", bus.IDEX_FLUSH, 1'b1);
    step(0, 1, 4'd3, 4'd5, 4'd3, 0, 0, 1);
    check("lu_rt_unused_pc_write", bus.PC_WRITE, 1'b1);
    step(0, 1, 4'd3, 4'd5, 4'd3, 1, 0, 1);
    step(0, 1, 4'd0, 4'd0, 4'd7, 0, 0, 1);
    step(0, 0, 4'd4, 4'd4, 4'd4, 1, 0, 1);
    step(0, 1, 4'd15, 4'd2, 4'd15, 1, 0, 1);

    // One-cycle branch pulse -> three flush cycles
    step(1, 0, 4'd0, 4'd1, 4'd2, 0, 0, 1);
    step(1, 1, 4'd3, 4'd3, 4'd0, 0, 0, 1);
    check("br_flush_state", bus.STATE, 2'b01);
    step(0, 1, 4'd3, 4'd3, 4'd0, 0, 0, 1);
    step(0, 0, 4'd0, 4'd1, 4'd2, 0, 0, 1);
    check("br_done_flush", bus.IDEX_FLUSH, 1'b0);

    // Five not-ready cycles, then ready
    for (int i = 0; i < 5; i++) step(0, 0, 4'd0, 4'd1, 4'd2, 0, 1, 0);
    step(0, 0, 4'd0, 4'd1, 4'd2, 0, 1, 1);
    check("memwait_release_hold", bus.PIPE_HOLD, 1'b0);
    idle(1);

    // Mem stall in the middle of a branch flush freezes the flush count
    step(1, 0, 4'd0, 4'd1, 4'd2, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 4'd0, 4'd1, 4'd2, 0, 1, 0);
    step(0, 0, 4'd0, 4'd1, 4'd2, 0, 1, 1);
    step(0, 0, 4'd0, 4'd1, 4'd2, 0, 0, 1);
    idle(1);

    // Timeout: eight held cycles, then forced release with sticky error
    for (int i = 0; i < TB_TIMEOUT; i++) step(0, 0, 4'd0, 4'd1, 4'd2, 0, 1, 0);
    step(0, 0, 4'd0, 4'd1, 4'd2, 0, 1, 0);
    check("timeout_err", bus.MEM_ERR, 1'b1);
    check("timeout_release", bus.PIPE_HOLD, 1'b0);
    idle(4);
    mid_reset("rst_clr_err");
    idle(1);

    // Mem-wait, branch and load-use together: only the hold wins
    for (int i = 0; i < 3; i++) step(1, 1, 4'd3, 4'd3, 4'd0, 0, 1, 0);
    step(1, 1, 4'd3, 4'd3, 4'd0, 0, 1, 1);
    check("combo_branch_flush", bus.IFID_FLUSH, 1'b1);
    step(0, 0, 4'd0, 4'd1, 4'd2, 0, 0, 1);
    step(0, 0, 4'd0, 4'd1, 4'd2, 0, 0, 1);
    idle(1);

    // Reset aborts FLUSH and MEMWAIT
    step(1, 0, 4'd0, 4'd1, 4'd2, 0, 0, 1);
    mid_reset("rst_mid_flush");
    idle(1);
    step(0, 0, 4'd0, 4'd1, 4'd2, 0, 1, 0);
    step(0, 0, 4'd0, 4'd1, 4'd2, 0, 1, 0);
    mid_reset("rst_mid_memwait");
    idle(1);

    // Constrained random; branch and mem access stay put while the pipe is held
    r_br = 1'b0;
    r_ma = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!m_prev_hold) begin
        r_br = ($urandom_range(0, 7) == 0);
        r_ma = ($urandom_range(0, 2) == 0);
      end
      r_ex = 4'($urandom_range(0, 3));
      r_rs = 4'($urandom_range(0, 3));
      r_rt = 4'($urandom_range(0, 3));
      step(r_br, 1'($urandom_range(0, 1)), r_ex, r_rs, r_rt, 1'($urandom_range(0, 1)),
           r_ma, (i % 200 > 150) ? 1'b0 : 1'($urandom_range(0, 2) != 0));
      if (i == 300) begin
        mid_reset("rst_random");
        r_br = 1'b0;
        r_ma = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
